assoc_wb_cache: RTL

- Parametrised 2-way set-associative write-back, write-allocate data cache with multi-word lines.
- Sits between the CPU load/store stage and main memory.
- Memory side uses a req/ack line-transfer handshake instead of fixed wait-cycle counts.
- Adds per-set LRU replacement and variable memory latency.

---
 rtl/assoc_wb_cache_if.sv | 16 +
 rtl/assoc_wb_cache.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/assoc_wb_cache_if.sv
// Line-transfer memory bus for assoc_wb_cache: one request, one ack pulse per line.
interface assoc_wb_cache_if #(
  parameter int WORD_BITS = 2
);
  localparam int LINE_W = 32 << WORD_BITS;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/assoc_wb_cache.sv
// 2-way set-associative write-back / write-allocate data cache, LRU per set.
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module assoc_wb_cache #(
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_en,
  input  logic             write_en,
  input  logic             is_byte,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  output logic [31:0]      data_out,
  output logic             ready,
  assoc_wb_cache_if.master mem
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [31:0]      wb_count
`endif
);
  localparam int LINE_W = 32 << WORD_BITS;
  localparam int NSETS  = 1 << SET_BITS;
  localparam int OFF_W  = WORD_BITS + 2;
  localparam int TAG_W  = 32 - SET_BITS - OFF_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state_reg, state_next;

  logic [TAG_W-1:0]  tag_mem  [2][NSETS];
  logic [LINE_W-1:0] data_mem [2][NSETS];
  logic [NSETS-1:0]  valid_reg [2];
  logic [NSETS-1:0]  dirty_reg [2];
  logic [NSETS-1:0]  lru_reg;
  logic              victim_reg;

  logic [SET_BITS-1:0]  set_idx;
  logic [TAG_W-1:0]     tag;
  logic [WORD_BITS-1:0] word_idx;
  logic [4:0]           shift;
  logic [31:0]          refill_addr;

  assign set_idx     = in_addr[OFF_W +: SET_BITS];
  assign tag         = in_addr[31 -: TAG_W];
  assign word_idx    = in_addr[2 +: WORD_BITS];
  assign shift       = {~in_addr[1:0], 3'b000};  // big-endian byte lane
  assign refill_addr = {in_addr[31:OFF_W], {OFF_W{1'b0}}};

  logic [1:0]        way_hit;
  logic [LINE_W-1:0] way_line [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    assign way_line[gi] = data_mem[gi][set_idx];
    assign way_hit[gi]  = valid_reg[gi][set_idx] && (tag_mem[gi][set_idx] == tag);
  end

  logic req, store, hit, hit_way, idle_hit, idle_miss;
  logic victim_sel, victim_dirty, acc_en, acc_way;
  logic [LINE_W-1:0] acc_line, merged_line;
  logic [31:0] acc_word, load_val, merged_word;

  assign req       = read_en | write_en;
  assign store     = ~read_en & write_en;
  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign idle_hit  = (state_reg == IDLE) && req && hit;
  assign idle_miss = (state_reg == IDLE) && req && !hit;

  // Fill empty ways in order before evicting the least recently used one.
  assign victim_sel   = !valid_reg[0][set_idx] ? 1'b0 :
                        !valid_reg[1][set_idx] ? 1'b1 : lru_reg[set_idx];
  assign victim_dirty = valid_reg[victim_sel][set_idx] && dirty_reg[victim_sel][set_idx];

  assign acc_en   = idle_hit || (state_reg == RESPOND);
  assign acc_way  = (state_reg == RESPOND) ? victim_reg : hit_way;
  assign acc_line = way_line[acc_way];
  assign acc_word = acc_line[{word_idx, 5'b00000} +: 32];
  assign load_val = is_byte ? {24'h0, acc_word[shift +: 8]} : acc_word;
  assign merged_word = is_byte ?
                       ((acc_word & ~(32'hFF << shift)) | ({24'h0, in_data[7:0]} << shift)) :
                       in_data;

  always_comb begin
    merged_line = acc_line;
    merged_line[{word_idx, 5'b00000} +: 32] = merged_word;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (idle_miss) state_next = victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem.ack) state_next = REFILL;
      REFILL:    if (mem.ack) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_reg == IDLE);
    mem.req = (state_reg == WRITEBACK) || (state_reg == REFILL);
    mem.we  = (state_reg == WRITEBACK);
  end

  // Tag and data arrays carry no reset so they can map onto RAM.
  always_ff @(negedge clk) begin
    if (state_reg == REFILL && mem.ack) begin
      data_mem[victim_reg][set_idx] <= mem.rdata;
      tag_mem[victim_reg][set_idx]  <= tag;
    end else if (acc_en && store) begin
      data_mem[acc_way][set_idx] <= merged_line;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg[0] <= '0;
      valid_reg[1] <= '0;
      dirty_reg[0] <= '0;
      dirty_reg[1] <= '0;
      lru_reg      <= '0;
      victim_reg   <= 1'b0;
      mem.addr     <= '0;
      mem.wdata    <= '0;
      data_out     <= '0;
    end else begin
      if (idle_miss) begin
        victim_reg <= victim_sel;
        if (victim_dirty) begin
          mem.addr  <= {tag_mem[victim_sel][set_idx], set_idx, {OFF_W{1'b0}}};
          mem.wdata <= way_line[victim_sel];
        end else begin
          mem.addr  <= refill_addr;
        end
      end
      if (state_reg == WRITEBACK && mem.ack) begin
        dirty_reg[victim_reg][set_idx] <= 1'b0;
        mem.addr <= refill_addr;
      end
      if (state_reg == REFILL && mem.ack) begin
        valid_reg[victim_reg][set_idx] <= 1'b1;
        dirty_reg[victim_reg][set_idx] <= 1'b0;
      end
      if (acc_en) begin
        lru_reg[set_idx] <= ~acc_way;
        if (store) dirty_reg[acc_way][set_idx] <= 1'b1;
        else       data_out <= load_val;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (idle_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (idle_miss && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (state_reg == WRITEBACK && mem.ack && wb_count != '1) wb_count <= wb_count + 32'd1;
    end
  end
`endif
endmodule
